// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, constants and word helpers for the key schedule and round datapath
package aes_pkg;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;
  localparam int         NR         = 10;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box; i_byte in, o_byte = SubBytes(i_byte) out
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  import aes_pkg::*;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_byte = SBOX[i_byte];
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule streaming round keys 0..10 over valid/ready
// ports: key/key_valid/key_ready = cipher key in; rk/rk_round/rk_last/rk_valid/rk_ready = round key out
// option AES_KEY_STORE_EN adds rd_idx/rd_key, an 11-entry replay store of the last schedule
module aes_key_expand #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] key,
  input  logic          key_valid,
  output logic          key_ready,
  output logic [KW-1:0] rk,
  output logic [3:0]    rk_round,
  output logic          rk_last,
  output logic          rk_valid,
  input  logic          rk_ready
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]    rd_idx,
  output logic [KW-1:0] rd_key
`endif
);
  import aes_pkg::*;
  typedef enum logic {IDLE, RUN} state_t;
  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_rk;
  logic [3:0]    r_round;
  logic [7:0]    r_rcon;
  word_t         w_rot, w_sub, w_t, w_n0, w_n1, w_n2, w_n3;
  logic          w_key_fire, w_rk_fire;
  if (NR != 10 || KW != 128) begin : g_bad_cfg
    $error("aes_key_expand supports only AES-128 (NR=10, KW=128)");
  end
  assign w_rot = rot_word(r_rk[31:0]);
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.i_byte(w_rot[8*i +: 8]), .o_byte(w_sub[8*i +: 8]));
  end
  assign w_t  = w_sub ^ {r_rcon, 24'h0};
  assign w_n0 = r_rk[127:96] ^ w_t;
  assign w_n1 = r_rk[95:64] ^ w_n0;
  assign w_n2 = r_rk[63:32] ^ w_n1;
  assign w_n3 = r_rk[31:0] ^ w_n2;
  assign w_key_fire = key_valid & key_ready;
  assign w_rk_fire  = rk_valid & rk_ready;
  assign rk       = r_rk;
  assign rk_round = r_round;
  assign rk_last  = r_round == 4'(NR);
  always_comb begin
    key_ready   = r_state == IDLE;
    rk_valid    = r_state == RUN;
    w_state_nxt = w_key_fire ? RUN : (w_rk_fire && rk_last) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // the last transfer leaves rk and rk_round in place for downstream visibility
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rk    <= '0;
      r_round <= '0;
      r_rcon  <= RCON_INIT;
    end else if (w_key_fire) begin
      r_rk    <= key;
      r_round <= '0;
      r_rcon  <= RCON_INIT;
    end else if (w_rk_fire && !rk_last) begin
      r_rk    <= {w_n0, w_n1, w_n2, w_n3};
      r_round <= r_round + 4'd1;
      r_rcon  <= xtime(r_rcon);
    end
`ifdef AES_KEY_STORE_EN
  logic [KW-1:0] r_store [0:NR];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int j = 0; j <= NR; j++) r_store[j] <= '0;
    else if (w_rk_fire) r_store[r_round] <= r_rk;
  assign rd_key = (rd_idx <= 4'(NR)) ? r_store[rd_idx] : '0;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: self-checking bench for aes_key_expand against a FIPS-197 style schedule model
module tb_aes_key_expand;
  typedef logic [10:0][127:0] sched_t;
  typedef struct {
    logic [127:0] key;
    int           round;
    logic [127:0] exp;
  } vec_t;
  logic         clk = 0;
  logic         rst_n;
  logic [127:0] key;
  logic         key_valid, key_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_last, rk_valid, rk_ready;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif
  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];
  always #5 clk = ~clk;
  aes_key_expand dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .rk(rk), .rk_round(rk_round), .rk_last(rk_last), .rk_valid(rk_valid), .rk_ready(rk_ready)
`ifdef AES_KEY_STORE_EN
    , .rd_idx(rd_idx), .rd_key(rd_key)
`endif
  );
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction
  // S-box derived from the GF(2^8) inverse and the affine map, not from a table
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask
  function automatic sched_t expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction
  // called at a negedge with the block idle; returns at the negedge after the last transfer
  task automatic run_expand(input logic [127:0] k, input int stall, input int inj, output sched_t got);
    int n;
    chk("key_ready before key", key_ready, 1);
    key = k;
    key_valid = 1;
    @(negedge clk);
    key_valid = 0;
    for (int r = 0; r <= 10; r++) begin
      chk($sformatf("rk_valid r%0d", r), rk_valid, 1);
      chk($sformatf("rk_round r%0d", r), rk_round, r);
      chk($sformatf("rk_last r%0d", r), rk_last, r == 10);
      got[r] = rk;
      if (r == inj) begin
        key = ~k;
        key_valid = 1;
      end
      if (r == inj + 1) key_valid = 0;
      n = 0;
      while (n < 6 && $urandom_range(99) < stall) begin
        rk_ready = 0;
        @(negedge clk);
        chk($sformatf("stall rk r%0d", r), rk, got[r]);
        chk($sformatf("stall round r%0d", r), rk_round, r);
        n++;
      end
      rk_ready = 1;
      @(negedge clk);
    end
    key_valid = 0;
    rk_ready = 0;
    chk("key_ready after last", key_ready, 1);
    chk("rk_valid after last", rk_valid, 0);
    chk("rk held after last", rk, got[10]);
    chk("rk_round held after last", rk_round, 10);
  endtask
  task automatic cmp_model(input string nm, input sched_t got, input logic [127:0] k);
    sched_t m = expand(k);
    for (int r = 0; r <= 10; r++) chk($sformatf("%s r%0d", nm, r), got[r], m[r]);
  endtask
  initial begin
    vec_t         vt [5];
    sched_t       g, a1;
    logic [127:0] k;
    vt[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1, 128'ha0fafe1788542cb123a339392a6c7605};
    vt[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[3] = '{128'h0, 1, 128'h62636363626363636263636362636363};
    vt[4] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    rst_n = 0;
    key = '0;
    key_valid = 0;
    rk_ready = 0;
`ifdef AES_KEY_STORE_EN
    rd_idx = 0;
`endif
    build_sbox();
    @(negedge clk);
    chk("reset rk", rk, 0);
    chk("reset rk_round", rk_round, 0);
    chk("reset rk_last", rk_last, 0);
    chk("reset rk_valid", rk_valid, 0);
    chk("reset key_ready", key_ready, 1);
    rst_n = 1;
    rk_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle rk_ready ignored valid", rk_valid, 0);
      chk("idle rk_ready ignored round", rk_round, 0);
    end
    rk_ready = 0;
    for (int i = 0; i < 5; i++) begin
      run_expand(vt[i].key, 0, -1, g);
      chk($sformatf("vector %0d round %0d", i, vt[i].round), g[vt[i].round], vt[i].exp);
    end
    run_expand(vt[0].key, 0, -1, a1);
    cmp_model("A1 model", a1, vt[0].key);
    run_expand(vt[0].key, 50, -1, g);
    for (int r = 0; r <= 10; r++) chk($sformatf("A1 stalled vs unstalled r%0d", r), g[r], a1[r]);
    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_expand(k, 40, -1, g);
      cmp_model($sformatf("rand%0d", i), g, k);
    end
    k = {$urandom, $urandom, $urandom, $urandom};
    run_expand(k, 20, 3, g);
    cmp_model("key during RUN ignored", g, k);
    k = {$urandom, $urandom, $urandom, $urandom};
    run_expand(k, 0, -1, g);
    cmp_model("back-to-back", g, k);
    k = {$urandom, $urandom, $urandom, $urandom};
    key = k;
    key_valid = 1;
    @(negedge clk);
    key_valid = 0;
    rk_ready = 1;
    repeat (5) @(negedge clk);
    chk("pre-reset round", rk_round, 5);
    rk_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("async reset rk", rk, 0);
    chk("async reset rk_round", rk_round, 0);
    chk("async reset rk_last", rk_last, 0);
    chk("async reset rk_valid", rk_valid, 0);
    chk("async reset key_ready", key_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    k = {$urandom, $urandom, $urandom, $urandom};
    run_expand(k, 0, -1, g);
    cmp_model("after reset", g, k);
`ifdef AES_KEY_STORE_EN
    run_expand(vt[0].key, 30, -1, g);
    rd_idx = 1;
    #1 chk("store idx1", rd_key, vt[1].exp);
    rd_idx = 10;
    #1 chk("store idx10", rd_key, vt[2].exp);
    rd_idx = 0;
    #1 chk("store idx0", rd_key, vt[0].key);
    rd_idx = 12;
    #1 chk("store idx12", rd_key, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
